// File: rtl/of_issue_if.sv
// of_issue_if: fetch-side handshake, write-back port and OF/EX latch outputs
// of the SimpleRISC operand-fetch/issue stage.
// The stage connects through the slave modport. The fetch/EX/WB side, or a
// bench, drives it through the master modport.
interface of_issue_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            of_ready;
    logic            ex_stall;
    logic            flush;
    logic            wb_we;
    logic [3:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] branchTarget;
    logic [4:0]      Alu_Signal;
    logic            isRet;
    logic            isBeq;
    logic            isBgt;
    logic            isUbranch;
    logic            isLd;
    logic            isSt;
    logic            isWb;
    logic [3:0]      ex_rd;

    modport master (
        output if_valid, if_pc, if_instr, ex_stall, flush, wb_we, wb_rd, wb_data,
        input  of_ready, ex_valid, ex_pc, op1, B, op2, branchTarget, Alu_Signal,
               isRet, isBeq, isBgt, isUbranch, isLd, isSt, isWb, ex_rd
    );

    modport slave (
        input  if_valid, if_pc, if_instr, ex_stall, flush, wb_we, wb_rd, wb_data,
        output of_ready, ex_valid, ex_pc, op1, B, op2, branchTarget, Alu_Signal,
               isRet, isBeq, isBgt, isUbranch, isLd, isSt, isWb, ex_rd
    );
endinterface

// File: rtl/of_issue_stage.sv
// of_issue_stage: SimpleRISC operand fetch / issue.
// The stage decodes the fetched instruction and reads the 16-entry register
// file, which it owns. It builds the immediate and the branch target, and it
// registers the result into the OF/EX latch.
// A pending-write scoreboard interlocks RAW and WAW hazards, because the
// pipeline has no forwarding.
// Build option: OF_WB_BYPASS_EN. When it is defined, a source register that is
// being written back in the same cycle reads wb_data and does not stall.
module of_issue_stage #(
    parameter int XLEN   = 32,
    parameter int RA_IDX = 15
) (
    input logic         clk,
    input logic         rst_n,
    of_issue_if.slave   bus
);
    localparam logic [3:0] RA_REG  = 4'(RA_IDX);
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_ALU_LAST = 5'd12;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] tgt;
        logic [4:0]      alu;
        logic            isRet;
        logic            isBeq;
        logic            isBgt;
        logic            isUbranch;
        logic            isLd;
        logic            isSt;
        logic            isWb;
        logic [3:0]      rd;
    } latch_t;

    logic [XLEN-1:0] regFile_r [16];
    logic [15:0]     pending_r;
    logic            exValid_r;
    latch_t          latch_r;

    logic [4:0]      opcode_s;
    logic            immSel_s;
    logic [3:0]      rd_s, rs1_s, rs2_s;
    logic [1:0]      modifier_s;
    logic [15:0]     imm16_s;
    logic [26:0]     offset_s;
    logic            isAluOp_s, isCall_s;
    logic            useRs1_s, useRs2_s, useRd_s, useRa_s;
    logic [XLEN-1:0] imm_s, rs1Val_s, rs2Val_s, rdVal_s, raVal_s;
    logic [15:0]     bypassHit_s, srcPend_s, clrMask_s, setMask_s;
    logic            hazard_s, issue_s;
    latch_t          dec_s;

    assign opcode_s   = bus.if_instr[31:27];
    assign immSel_s   = bus.if_instr[26];
    assign rd_s       = bus.if_instr[25:22];
    assign rs1_s      = bus.if_instr[21:18];
    assign rs2_s      = bus.if_instr[17:14];
    assign modifier_s = bus.if_instr[17:16];
    assign imm16_s    = bus.if_instr[15:0];
    assign offset_s   = bus.if_instr[26:0];

    // Registers written back this very cycle that may be read directly from wb_data.
    always_comb begin
        bypassHit_s = 16'd0;
`ifdef OF_WB_BYPASS_EN
        if (bus.wb_we) begin
            bypassHit_s = 16'd1 << bus.wb_rd;
        end else begin
            bypassHit_s = 16'd0;
        end
`endif
    end

    assign rs1Val_s = bypassHit_s[rs1_s]  ? bus.wb_data : regFile_r[rs1_s];
    assign rs2Val_s = bypassHit_s[rs2_s]  ? bus.wb_data : regFile_r[rs2_s];
    assign rdVal_s  = bypassHit_s[rd_s]   ? bus.wb_data : regFile_r[rd_s];
    assign raVal_s  = bypassHit_s[RA_REG] ? bus.wb_data : regFile_r[RA_REG];

    assign isAluOp_s = (opcode_s <= OP_ALU_LAST);
    assign isCall_s  = (opcode_s == OP_CALL);
    assign useRs1_s  = (isAluOp_s && (opcode_s != OP_NOT) && (opcode_s != OP_MOV))
                       || (opcode_s == OP_LD) || (opcode_s == OP_ST);
    assign useRs2_s  = isAluOp_s && !immSel_s;
    assign useRd_s   = (opcode_s == OP_ST);
    assign useRa_s   = (opcode_s == OP_RET);

    // Immediate formation from the modifier field; 11 behaves like 00.
    always_comb begin
        case (modifier_s)
            2'b01:   imm_s = {{(XLEN-16){1'b0}}, imm16_s};
            2'b10:   imm_s = {{(XLEN-32){1'b0}}, imm16_s, 16'h0000};
            default: imm_s = {{(XLEN-16){imm16_s[15]}}, imm16_s};
        endcase
    end

    // Decoded contents of the OF/EX latch for the instruction currently in OF.
    always_comb begin
        dec_s           = '0;
        dec_s.pc        = bus.if_pc;
        dec_s.tgt       = bus.if_pc + {{(XLEN-29){offset_s[26]}}, offset_s, 2'b00};
        dec_s.alu       = isAluOp_s ? opcode_s : 5'd0;
        dec_s.isRet     = (opcode_s == OP_RET);
        dec_s.isBeq     = (opcode_s == OP_BEQ);
        dec_s.isBgt     = (opcode_s == OP_BGT);
        dec_s.isUbranch = (opcode_s == OP_B) || isCall_s || (opcode_s == OP_RET);
        dec_s.isLd      = (opcode_s == OP_LD);
        dec_s.isSt      = (opcode_s == OP_ST);
        dec_s.isWb      = (isAluOp_s && (opcode_s != OP_CMP)) || (opcode_s == OP_LD) || isCall_s;
        dec_s.rd        = isCall_s ? RA_REG : rd_s;
        dec_s.op2       = (opcode_s == OP_ST) ? rdVal_s : {XLEN{1'b0}};
        if (isCall_s) begin
            dec_s.op1 = bus.if_pc;
            dec_s.b   = {{(XLEN-3){1'b0}}, 3'd4};
        end else if (opcode_s == OP_RET) begin
            dec_s.op1 = raVal_s;
            dec_s.b   = immSel_s ? imm_s : rs2Val_s;
        end else if ((opcode_s == OP_LD) || (opcode_s == OP_ST) || immSel_s) begin
            dec_s.op1 = rs1Val_s;
            dec_s.b   = imm_s;
        end else begin
            dec_s.op1 = rs1Val_s;
            dec_s.b   = rs2Val_s;
        end
    end

    // A source that is being bypassed this cycle no longer counts as pending.
    assign srcPend_s = pending_r & ~bypassHit_s;
    assign hazard_s  = (useRs1_s && srcPend_s[rs1_s]) || (useRs2_s && srcPend_s[rs2_s])
                     || (useRd_s && srcPend_s[rd_s]) || (useRa_s && srcPend_s[RA_REG])
                     || (dec_s.isWb && pending_r[dec_s.rd]);
    assign issue_s   = bus.if_valid && !bus.ex_stall && !bus.flush && !hazard_s;
    assign bus.of_ready = !bus.ex_stall && !hazard_s;

    // The set is applied after the clear, so an issue to the same index wins.
    assign clrMask_s = bus.wb_we ? (16'd1 << bus.wb_rd) : 16'd0;
    assign setMask_s = (issue_s && dec_s.isWb) ? (16'd1 << dec_s.rd) : 16'd0;

    // Scoreboard of destinations with a write still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 16'd0;
        end else begin
            pending_r <= (pending_r & ~clrMask_s) | setMask_s;
        end
    end

    // Register file, written by the WB stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regFile_r[i] <= {XLEN{1'b0}};
            end
        end else if (bus.wb_we) begin
            regFile_r[bus.wb_rd] <= bus.wb_data;
        end
    end

    // OF/EX latch: flush beats stall, stall holds, otherwise issue or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid_r <= 1'b0;
            latch_r   <= '0;
        end else if (bus.flush) begin
            exValid_r <= 1'b0;
        end else if (bus.ex_stall) begin
            exValid_r <= exValid_r;
        end else if (issue_s) begin
            exValid_r <= 1'b1;
            latch_r   <= dec_s;
        end else begin
            exValid_r <= 1'b0;
        end
    end

    assign bus.ex_valid     = exValid_r;
    assign bus.ex_pc        = latch_r.pc;
    assign bus.op1          = latch_r.op1;
    assign bus.B            = latch_r.b;
    assign bus.op2          = latch_r.op2;
    assign bus.branchTarget = latch_r.tgt;
    assign bus.Alu_Signal   = latch_r.alu;
    assign bus.isRet        = latch_r.isRet;
    assign bus.isBeq        = latch_r.isBeq;
    assign bus.isBgt        = latch_r.isBgt;
    assign bus.isUbranch    = latch_r.isUbranch;
    assign bus.isLd         = latch_r.isLd;
    assign bus.isSt         = latch_r.isSt;
    assign bus.isWb         = latch_r.isWb;
    assign bus.ex_rd        = latch_r.rd;
endmodule

// File: tb/tb_of_issue_stage.sv
// tb_of_issue_stage: directed vector table, hand-written hazard, stall, flush
// and reset sequences, then random traffic checked against a mnemonic-level
// reference model of the register file and the scoreboard.
module tb_of_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    of_issue_if #(.XLEN(32)) bus();
    of_issue_stage #(.XLEN(32), .RA_IDX(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] F_RET = 7'b1000000, F_BEQ = 7'b0100000, F_BGT = 7'b0010000,
                           F_UB  = 7'b0001000, F_LD  = 7'b0000100, F_ST  = 7'b0000010,
                           F_WB  = 7'b0000001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkI(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [1:0] md, input logic [15:0] imm);
        return {op, 1'b1, rd, rs1, md, imm};
    endfunction
    function automatic logic [31:0] mkR(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction
    function automatic logic [31:0] mkB(input logic [4:0] op, input logic [26:0] off);
        return {op, off};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr, input logic st,
                         input logic fl, input logic we, input logic [3:0] wrd, input logic [31:0] wd);
        bus.if_valid = v;   bus.if_pc = pc;  bus.if_instr = instr;
        bus.ex_stall = st;  bus.flush = fl;
        bus.wb_we = we;     bus.wb_rd = wrd; bus.wb_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkFields(input string t, input logic c1, input logic [31:0] op1, input logic cB,
                             input logic [31:0] b, input logic [4:0] alu, input logic [3:0] rd,
                             input logic [6:0] flags, input logic cT, input logic [31:0] tgt,
                             input logic cO2, input logic [31:0] op2, input logic [31:0] pc);
        chk({t, "_valid"}, bus.ex_valid, 32'd1);
        chk({t, "_pc"}, bus.ex_pc, pc);
        if (c1)  chk({t, "_op1"}, bus.op1, op1);
        if (cB)  chk({t, "_B"}, bus.B, b);
        chk({t, "_alu"}, bus.Alu_Signal, alu);
        chk({t, "_rd"}, bus.ex_rd, rd);
        chk({t, "_flags"}, {bus.isRet, bus.isBeq, bus.isBgt, bus.isUbranch, bus.isLd, bus.isSt, bus.isWb}, flags);
        if (cT)  chk({t, "_tgt"}, bus.branchTarget, tgt);
        if (cO2) chk({t, "_op2"}, bus.op2, op2);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string name; logic [31:0] pc, instr; logic preWe; logic [3:0] preRd; logic [31:0] preData;
        logic c1; logic [31:0] op1; logic cB; logic [31:0] b; logic [4:0] alu; logic [3:0] rd;
        logic [6:0] flags; logic cT; logic [31:0] tgt; logic cO2; logic [31:0] op2;
    } vec_t;
    vec_t vecs[$];

    task automatic addVec(input string nm, input logic [31:0] pc, input logic [31:0] instr, input logic preWe,
                          input logic [3:0] preRd, input logic [31:0] preData, input logic c1, input logic [31:0] op1,
                          input logic cB, input logic [31:0] b, input logic [4:0] alu, input logic [3:0] rd,
                          input logic [6:0] flags, input logic cT, input logic [31:0] tgt, input logic cO2,
                          input logic [31:0] op2);
        vec_t v;
        v.name = nm; v.pc = pc; v.instr = instr; v.preWe = preWe; v.preRd = preRd; v.preData = preData;
        v.c1 = c1; v.op1 = op1; v.cB = cB; v.b = b; v.alu = alu; v.rd = rd; v.flags = flags;
        v.cT = cT; v.tgt = tgt; v.cO2 = cO2; v.op2 = op2;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc, op1, b, op2, tgt; logic [4:0] alu; logic [3:0] rd; logic [6:0] flags;
        logic c1, cB; logic [3:0] src [3]; int nSrc;
    } exp_t;

    logic [31:0] mRegs [16];
    logic        mPend [16];

    function automatic logic bypassHit(input logic [3:0] idx, input logic we, input logic [3:0] wrd);
`ifdef OF_WB_BYPASS_EN
        return we && (wrd == idx);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] readR(input logic [3:0] idx, input logic we, input logic [3:0] wrd,
                                          input logic [31:0] wd);
        return bypassHit(idx, we, wrd) ? wd : mRegs[idx];
    endfunction

    function automatic exp_t refDecode(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                                       input logic [3:0] wrd, input logic [31:0] wd);
        exp_t e;
        int op, offVal;
        logic [31:0] imm;
        logic [15:0] i16;
        op = int'(ins[31:27]);
        i16 = ins[15:0];
        if (ins[17:16] == 2'd1)      imm = {16'd0, i16};
        else if (ins[17:16] == 2'd2) imm = 32'(i16) * 32'd65536;
        else                         imm = 32'($signed(i16));
        offVal = ins[26] ? (int'(ins[26:0]) - 32'sd134217728) : int'(ins[26:0]);
        e.pc = pc; e.tgt = pc + 32'(offVal * 4);
        e.rd = ins[25:22]; e.alu = 5'd0; e.flags = 7'd0; e.op2 = 32'd0;
        e.c1 = 1'b1; e.cB = 1'b1; e.nSrc = 0;
        e.src[0] = 4'd0; e.src[1] = 4'd0; e.src[2] = 4'd0;
        e.op1 = readR(ins[21:18], we, wrd, wd);
        e.b = ins[26] ? imm : readR(ins[17:14], we, wrd, wd);
        if (op <= 12) begin
            e.alu = 5'(op);
            if (op != 5) e.flags = F_WB;
            if (op == 8 || op == 9) e.c1 = 1'b0;
            else begin e.src[e.nSrc] = ins[21:18]; e.nSrc++; end
            if (!ins[26]) begin e.src[e.nSrc] = ins[17:14]; e.nSrc++; end
        end else begin
            case (op)
                14: begin e.b = imm; e.flags = F_LD | F_WB; e.src[0] = ins[21:18]; e.nSrc = 1; end
                15: begin
                    e.b = imm; e.flags = F_ST; e.op2 = readR(ins[25:22], we, wrd, wd);
                    e.src[0] = ins[21:18]; e.src[1] = ins[25:22]; e.nSrc = 2;
                end
                16: begin e.flags = F_BEQ; e.c1 = 1'b0; e.cB = 1'b0; end
                17: begin e.flags = F_BGT; e.c1 = 1'b0; e.cB = 1'b0; end
                18: begin e.flags = F_UB;  e.c1 = 1'b0; e.cB = 1'b0; end
                19: begin e.op1 = pc; e.b = 32'd4; e.rd = 4'd15; e.flags = F_UB | F_WB; end
                20: begin
                    e.op1 = readR(4'd15, we, wrd, wd); e.cB = 1'b0; e.flags = F_RET | F_UB;
                    e.src[0] = 4'd15; e.nSrc = 1;
                end
                default: begin e.c1 = 1'b0; e.cB = 1'b0; end
            endcase
        end
        return e;
    endfunction

    function automatic logic refHazard(input exp_t e, input logic we, input logic [3:0] wrd);
        logic hz;
        hz = 1'b0;
        for (int k = 0; k < e.nSrc; k++)
            if (mPend[e.src[k]] && !bypassHit(e.src[k], we, wrd)) hz = 1'b1;
        if (e.flags[0] && mPend[e.rd]) hz = 1'b1;
        return hz;
    endfunction

    function automatic logic [3:0] pickReg();
        int r;
        r = $urandom_range(0, 6);
        return (r == 6) ? 4'd15 : 4'(r);
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        ins = $urandom;
        ins[31:27] = 5'($urandom_range(0, 31));
        ins[25:22] = pickReg();
        ins[21:18] = pickReg();
        if (!ins[26]) ins[17:14] = pickReg();
        return ins;
    endfunction

    task automatic doReset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        exp_t e, mLatch;
        logic mValid, hz, iss, v, st, fl, we;
        logic [3:0] wrd;
        logic [31:0] wd, pc, ins;

        doReset();
        chk("reset_valid", bus.ex_valid, 32'd0);
        chk("reset_op1", bus.op1, 32'd0);
        chk("reset_B", bus.B, 32'd0);
        chk("reset_ctrl", {bus.Alu_Signal, bus.isRet, bus.isBeq, bus.isBgt, bus.isUbranch, bus.isLd, bus.isSt, bus.isWb, bus.ex_rd}, 32'd0);
        chk("reset_ready", bus.of_ready, 32'd1);
        @(posedge clk); #1;

        addVec("add_imm",  32'h0,   mkI(5'd0, 4'd1, 4'd2, 2'd0, 16'd5), 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'd5, 5'd0, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("sub_rr",   32'h4,   mkR(5'd1, 4'd4, 4'd3, 4'd3), 1'b1, 4'd3, 32'h1234, 1'b1, 32'h1234, 1'b1, 32'h1234, 5'd1, 4'd4, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("mov_m10",  32'h8,   mkI(5'd9, 4'd1, 4'd0, 2'd2, 16'h8000), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h80000000, 5'd9, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("mov_m00",  32'hC,   mkI(5'd9, 4'd1, 4'd0, 2'd0, 16'h8000), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF8000, 5'd9, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("mov_m01",  32'h10,  mkI(5'd9, 4'd1, 4'd0, 2'd1, 16'h8000), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h00008000, 5'd9, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("mov_m11",  32'h14,  mkI(5'd9, 4'd1, 4'd0, 2'd3, 16'h8000), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF8000, 5'd9, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("beq_back", 32'h100, mkB(5'd16, 27'h7FFFFFE), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 4'd15, F_BEQ, 1'b1, 32'hF8, 1'b0, 32'd0);
        addVec("bgt_fwd",  32'h40,  mkB(5'd17, 27'd3), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 4'd0, F_BGT, 1'b1, 32'h4C, 1'b0, 32'd0);
        addVec("call",     32'h200, mkB(5'd19, 27'd0), 1'b0, 4'd0, 32'd0, 1'b1, 32'h200, 1'b1, 32'd4, 5'd0, 4'd15, F_UB | F_WB, 1'b1, 32'h200, 1'b0, 32'd0);
        addVec("ret",      32'h300, mkB(5'd20, 27'd0), 1'b1, 4'd15, 32'hCAFE0000, 1'b1, 32'hCAFE0000, 1'b0, 32'd0, 5'd0, 4'd0, F_RET | F_UB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("st",       32'h20,  mkI(5'd15, 4'd7, 4'd2, 2'd0, 16'd8), 1'b1, 4'd7, 32'h55, 1'b1, 32'd0, 1'b1, 32'd8, 5'd0, 4'd7, F_ST, 1'b0, 32'd0, 1'b1, 32'h55);
        addVec("ld",       32'h24,  mkI(5'd14, 4'd5, 4'd1, 2'd0, 16'hFFFC), 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'hFFFFFFFC, 5'd0, 4'd5, F_LD | F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("cmp",      32'h28,  mkR(5'd5, 4'd0, 4'd2, 4'd3), 1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b1, 32'h1234, 5'd5, 4'd0, 7'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("lsl_imm",  32'h2C,  mkI(5'd10, 4'd2, 4'd3, 2'd1, 16'd3), 1'b0, 4'd0, 32'd0, 1'b1, 32'h1234, 1'b1, 32'd3, 5'd10, 4'd2, F_WB, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("nop",      32'h30,  mkR(5'd13, 4'd0, 4'd0, 4'd0), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 4'd0, 7'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("op31",     32'h34,  mkR(5'd31, 4'd6, 4'd1, 4'd1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 4'd6, 7'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        addVec("b",        32'h10,  mkB(5'd18, 27'd1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 4'd0, F_UB, 1'b1, 32'h14, 1'b0, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].preWe) begin
                drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, vecs[i].preRd, vecs[i].preData);
                tick();
            end
            drive(1'b1, vecs[i].pc, vecs[i].instr, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
            #2 chk({vecs[i].name, "_ready"}, bus.of_ready, 32'd1);
            tick();
            chkFields(vecs[i].name, vecs[i].c1, vecs[i].op1, vecs[i].cB, vecs[i].b, vecs[i].alu, vecs[i].rd,
                      vecs[i].flags, vecs[i].cT, vecs[i].tgt, vecs[i].cO2, vecs[i].op2, vecs[i].pc);
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, vecs[i].flags[0], vecs[i].rd, 32'd0);
            tick();
            chk({vecs[i].name, "_bubble"}, bus.ex_valid, 32'd0);
        end

        // load-use interlock: add r6,r5,r5 waits for the load's write-back
        drive(1'b1, 32'h50, mkI(5'd14, 4'd5, 4'd1, 2'd0, 16'd0), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        chk("lu_ld_valid", bus.ex_valid, 32'd1);
        drive(1'b1, 32'h54, mkR(5'd0, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            #2 chk("lu_wait_ready", bus.of_ready, 32'd0);
            tick();
            chk("lu_wait_bubble", bus.ex_valid, 32'd0);
        end
        drive(1'b1, 32'h54, mkR(5'd0, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, 1'b1, 4'd5, 32'hABCD);
`ifdef OF_WB_BYPASS_EN
        #2 chk("lu_wb_ready", bus.of_ready, 32'd1);
        tick();
`else
        #2 chk("lu_wb_ready", bus.of_ready, 32'd0);
        tick();
        chk("lu_wb_bubble", bus.ex_valid, 32'd0);
        drive(1'b1, 32'h54, mkR(5'd0, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #2 chk("lu_after_ready", bus.of_ready, 32'd1);
        tick();
`endif
        chkFields("lu_add", 1'b1, 32'hABCD, 1'b1, 32'hABCD, 5'd0, 4'd6, F_WB, 1'b0, 32'd0, 1'b0, 32'd0, 32'h54);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd0);
        tick();

        // stall holds the latch
        drive(1'b1, 32'h60, mkI(5'd0, 4'd1, 4'd2, 2'd0, 16'd7), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        chkFields("stall_pre", 1'b1, 32'd0, 1'b1, 32'd7, 5'd0, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0, 32'h60);
        drive(1'b1, 32'h64, mkI(5'd0, 4'd7, 4'd2, 2'd0, 16'd9), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        #2 chk("stall_ready", bus.of_ready, 32'd0);
        tick();
        tick();
        chkFields("stall_hold", 1'b1, 32'd0, 1'b1, 32'd7, 5'd0, 4'd1, F_WB, 1'b0, 32'd0, 1'b0, 32'd0, 32'h60);

        // flush beats stall and the dropped instruction leaves no pending bit
        drive(1'b1, 32'h68, mkI(5'd0, 4'd9, 4'd2, 2'd0, 16'd1), 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
        tick();
        chk("flush_valid", bus.ex_valid, 32'd0);
        drive(1'b1, 32'h6C, mkR(5'd0, 4'd10, 4'd9, 4'd9), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #2 chk("flush_r9_free", bus.of_ready, 32'd1);
        tick();
        chk("flush_next_valid", bus.ex_valid, 32'd1);
        chk("flush_next_rd", bus.ex_rd, 32'd10);
        drive(1'b1, 32'h70, mkR(5'd0, 4'd11, 4'd1, 4'd1), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #2 chk("r1_still_pending", bus.of_ready, 32'd0);
        tick();

        // asynchronous reset in the middle of a stall
        drive(1'b1, 32'h74, mkR(5'd0, 4'd11, 4'd1, 4'd1), 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", bus.ex_valid, 32'd0);
        chk("rst_mid_ops", bus.op1 | bus.B | bus.op2 | bus.branchTarget | bus.ex_pc, 32'd0);
        chk("rst_mid_ctrl", {bus.Alu_Signal, bus.isRet, bus.isBeq, bus.isBgt, bus.isUbranch, bus.isLd, bus.isSt, bus.isWb, bus.ex_rd}, 32'd0);
        #1 rst_n = 1'b1;
        drive(1'b1, 32'h78, mkR(5'd0, 4'd12, 4'd3, 4'd1), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1 chk("rst_mid_ready", bus.of_ready, 32'd1);
        tick();
        chkFields("rst_regs_clr", 1'b1, 32'd0, 1'b1, 32'd0, 5'd0, 4'd12, F_WB, 1'b0, 32'd0, 1'b0, 32'd0, 32'h78);

        // random traffic against the reference model
        doReset();
        for (int r = 0; r < 16; r++) begin mRegs[r] = 32'd0; mPend[r] = 1'b0; end
        mValid = 1'b0;
        mLatch = refDecode(32'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 9) < 4);
            wrd = pickReg();
            wd = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            ins = randInstr();
            drive(v, pc, ins, st, fl, we, wrd, wd);
            e = refDecode(pc, ins, we, wrd, wd);
            hz = refHazard(e, we, wrd);
            #2 chk("rnd_ready", bus.of_ready, 32'(!st && !hz));
            iss = v && !st && !fl && !hz;
            if (fl) mValid = 1'b0;
            else if (!st) begin
                mValid = iss;
                if (iss) mLatch = e;
            end
            if (we) begin mRegs[wrd] = wd; mPend[wrd] = 1'b0; end
            if (iss && e.flags[0]) mPend[e.rd] = 1'b1;
            tick();
            if (mValid)
                chkFields("rnd", mLatch.c1, mLatch.op1, mLatch.cB, mLatch.b, mLatch.alu, mLatch.rd, mLatch.flags,
                          1'b1, mLatch.tgt, mLatch.flags[1], mLatch.op2, mLatch.pc);
            else
                chk("rnd_bubble", bus.ex_valid, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
